// File: rtl/fp32_divider_if.sv
// Start/done handshake and operand/result bundle for the FP32 divider.
// The controller side uses the master modport, the divider uses slave.
interface fp32_divider_if;
    logic        startDiv;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Result;
    logic        busy;
    logic        doneDiv;

    modport master (output startDiv, A, B, input Result, busy, doneDiv);
    modport slave  (input startDiv, A, B, output Result, busy, doneDiv);
endinterface

// File: rtl/fp32_divider.sv
// Sequential FP32 divider: 25-cycle restoring division of the significands, truncated result.
// Optional macro FP32_DIV_SPECIAL_EN adds zero/infinity/NaN and exponent range handling.
module fp32_divider (
    input  logic           clk,
    input  logic           rst,
    fp32_divider_if.slave  dif
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [24:0] rem;
    logic [24:0] quo;
    logic [4:0]  cnt;
    logic [31:0] result_reg;

    logic [24:0] mb;
    logic        qbit;
    logic [23:0] diff;
    logic [23:0] rem_d;

    // When the subtraction is taken the difference is below Mb < 2^24, so 24 bits suffice.
    assign mb    = {2'b01, b_reg[22:0]};
    assign qbit  = (rem >= mb);
    assign diff  = rem[23:0] - mb[23:0];
    assign rem_d = qbit ? diff : rem[23:0];

    function automatic logic [31:0] pack_result(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [24:0] q);
        logic              sign;
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic [31:0]       res;
        sign = a[31] ^ b[31];
        e    = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
             + (q[24] ? 10'sd127 : 10'sd126);
        frac = q[24] ? q[23:1] : q[22:0];
        res  = {sign, e[7:0], frac};
`ifdef FP32_DIV_SPECIAL_EN
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
            res = 32'h7FC0_0000;
        else if (b[30:23] == 8'd0)
            res = {sign, 8'hFF, 23'd0};
        else if (a[30:23] == 8'd0)
            res = {sign, 31'd0};
        else if (e >= 10'sd255)
            res = {sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            res = {sign, 31'd0};
`endif
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dif.startDiv) state_nxt = DIV;
            DIV:     if (cnt == 5'd0)  state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: if (dif.startDiv) begin
                    a_reg <= dif.A;
                    b_reg <= dif.B;
                    rem   <= {2'b01, dif.A[22:0]};
                    quo   <= '0;
                    cnt   <= 5'd24;
                end
                DIV: begin
                    quo <= {quo[23:0], qbit};
                    rem <= {rem_d, 1'b0};
                    if (cnt != 5'd0)
                        cnt <= cnt - 5'd1;
                end
                NORM:    result_reg <= pack_result(a_reg, b_reg, quo);
                default: ;
            endcase
        end
    end

    assign dif.Result  = result_reg;
    assign dif.busy    = (state != IDLE);
    assign dif.doneDiv = (state == DONE);

endmodule

// File: tb/tb_fp32_divider.sv
// Directed testbench for fp32_divider: results, handshake timing, restart, abort.
// Build with FP32_DIV_SPECIAL_EN defined to cover the special-case rules.
module tb_fp32_divider;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    fp32_divider_if dif();

    fp32_divider dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one division from IDLE; edges are numbered from the accepting edge 0.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int done_cnt,
                          output int done_edge, output int idle_edge);
        dif.A        = a;
        dif.B        = b;
        dif.startDiv = 1'b1;
        @(posedge clk); #1;
        dif.startDiv = 1'b0;
        res       = '0;
        done_cnt  = 0;
        done_edge = -1;
        idle_edge = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (dif.doneDiv) begin
                done_cnt++;
                done_edge = i;
                res       = dif.Result;
            end
            if (!dif.busy && idle_edge < 0) idle_edge = i;
            if (idle_edge >= 0 && i >= idle_edge + 2) break;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        dif.startDiv = 1'b1;
        dif.A        = 32'h4040_0000;
        dif.B        = 32'h4000_0000;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dif.Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result got %h want 00000000", dif.Result);
        end
        tests_run++;
        if (dif.busy !== 1'b0 || dif.doneDiv !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got busy=%b done=%b want 0 0", dif.busy, dif.doneDiv);
        end
        dif.startDiv = 1'b0;
        rst          = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle got busy=%b want 0", dif.busy);
        end
    endtask

    task automatic test_divide(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
        logic [31:0] res;
        int          dc, de, ie;
        do_div(a, b, res, dc, de, ie);
        tests_run++;
        if (res !== expected) begin
            tests_failed++;
            $display("FAIL %s result got %h want %h", name, res, expected);
        end
        tests_run++;
        if (dc != 1 || de != 26) begin
            tests_failed++;
            $display("FAIL %s done got count=%0d edge=%0d want count=1 edge=26", name, dc, de);
        end
        tests_run++;
        if (ie != 27) begin
            tests_failed++;
            $display("FAIL %s idle_edge got %0d want 27", name, ie);
        end
    endtask

    task automatic test_restart_ignored();
        logic [31:0] res;
        int          dones, de;
        logic        busy_ok, busy27;
        dif.A        = 32'h4040_0000;
        dif.B        = 32'h4000_0000;
        dif.startDiv = 1'b1;
        @(posedge clk); #1;
        dif.startDiv = 1'b0;
        res = '0; dones = 0; de = -1; busy_ok = 1'b1; busy27 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                dif.startDiv = 1'b1;
                dif.A        = 32'h3F80_0000;
                dif.B        = 32'h4040_0000;
            end
            if (i == 8) dif.startDiv = 1'b0;
            @(posedge clk); #1;
            if (i <= 26 && dif.busy !== 1'b1) busy_ok = 1'b0;
            if (i == 27) busy27 = dif.busy;
            if (dif.doneDiv) begin
                dones++;
                de  = i;
                res = dif.Result;
            end
        end
        tests_run++;
        if (res !== 32'h3FC0_0000) begin
            tests_failed++;
            $display("FAIL restart_result got %h want 3fc00000", res);
        end
        tests_run++;
        if (dones != 1 || de != 26) begin
            tests_failed++;
            $display("FAIL restart_done got count=%0d edge=%0d want 1 26", dones, de);
        end
        tests_run++;
        if (busy_ok !== 1'b1 || busy27 !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_busy got held=%b at27=%b want 1 0", busy_ok, busy27);
        end
    endtask

    task automatic test_hold_start();
        logic [31:0] res1, res2;
        int          de1, de2;
        logic        busy27, busy28;
        dif.A        = 32'h4040_0000;
        dif.B        = 32'h4000_0000;
        dif.startDiv = 1'b1;
        @(posedge clk); #1;
        res1 = '0; res2 = '0; de1 = -1; de2 = -1; busy27 = 1'b1; busy28 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (dif.doneDiv) begin
                if (de1 < 0) begin
                    de1  = i;
                    res1 = dif.Result;
                    dif.A = 32'h3F80_0000;
                    dif.B = 32'h4040_0000;
                end else begin
                    de2  = i;
                    res2 = dif.Result;
                end
            end
            if (i == 27) busy27 = dif.busy;
            if (i == 28) begin
                busy28       = dif.busy;
                dif.startDiv = 1'b0;
            end
        end
        tests_run++;
        if (res1 !== 32'h3FC0_0000 || de1 != 26) begin
            tests_failed++;
            $display("FAIL hold_first got %h at %0d want 3fc00000 at 26", res1, de1);
        end
        tests_run++;
        if (busy27 !== 1'b0 || busy28 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_restart got busy27=%b busy28=%b want 0 1", busy27, busy28);
        end
        tests_run++;
        if (res2 !== 32'h3EAA_AAAA || de2 != 54) begin
            tests_failed++;
            $display("FAIL hold_second got %h at %0d want 3eaaaaaa at 54", res2, de2);
        end
    endtask

    task automatic test_rst_abort();
        int dones;
        dif.A        = 32'h4040_0000;
        dif.B        = 32'h4000_0000;
        dif.startDiv = 1'b1;
        @(posedge clk); #1;
        dif.startDiv = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (dif.busy !== 1'b0 || dif.doneDiv !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", dif.busy, dif.doneDiv);
        end
        tests_run++;
        if (dif.Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_result got %h want 00000000", dif.Result);
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (dif.doneDiv) dones++;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done got %0d pulses want 0", dones);
        end
        test_divide("after_abort", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
    endtask

`ifdef FP32_DIV_SPECIAL_EN
    task automatic test_special();
        test_divide("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        test_divide("overflow",    32'h7F00_0000, 32'h0080_0001, 32'h7F80_0000);
        test_divide("zero_num",    32'h0000_0000, 32'hBF80_0000, 32'h8000_0000);
        test_divide("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
        test_divide("underflow",   32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);
    endtask
`else
    task automatic test_wrap();
        test_divide("exp_wrap",    32'h7F00_0000, 32'h0080_0001, 32'h3DFF_FFFE);
        test_divide("zero_as_one", 32'h3F80_0000, 32'h0000_0000, 32'h7F00_0000);
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        dif.startDiv = 1'b0;
        dif.A        = '0;
        dif.B        = '0;
        test_reset();
        test_divide("div_3_2",   32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000);
        test_divide("div_1_3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
        test_divide("div_m6_15", 32'hC0C0_0000, 32'h3FC0_0000, 32'hC080_0000);
        test_restart_ignored();
        test_hold_start();
        test_rst_abort();
`ifdef FP32_DIV_SPECIAL_EN
        test_special();
`else
        test_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
